// File: rtl/database_scheduler.sv
// Round-robin owner of the shared Haar database: one sweep per scale at a time,
// then per-pixel candidate collection, result write and pixel release.
module database_scheduler #(
  parameter int NUM_RESIZE     = 5,
  parameter int INDEX_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RESIZE-1:0]  database_request,
  input  logic [NUM_RESIZE-1:0]  pixel_request,
  input  logic [NUM_RESIZE-1:0]  candidate,
  input  logic                   database_end,
  input  logic                   result_write_end,
  input  logic                   pixel_recieve,
  output logic [NUM_RESIZE-1:0]  o_grant,
  output logic [INDEX_WIDTH-1:0] o_grant_index,
  output logic                   o_database_reset,
  output logic                   o_database_enable,
  output logic [NUM_RESIZE-1:0]  o_candidate,
  output logic                   o_write_result,
  output logic                   o_ready_recieve_pixel,
  output logic                   o_busy,
  output logic                   o_timeout
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SWEEP      = 3'd2,
    COLLECT    = 3'd3,
    WRITE      = 3'd4,
    READY      = 3'd5,
    WAIT_PIXEL = 3'd6
  } state_t;

  localparam logic [15:0]            SWEEP_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [INDEX_WIDTH-1:0] PTR_RESET  = INDEX_WIDTH'(NUM_RESIZE - 1);

  state_t                 state_r;
  logic [INDEX_WIDTH-1:0] ptr_r;
  logic [15:0]            sweep_cnt_r;
  logic [NUM_RESIZE-1:0]  cand_r;
  logic [INDEX_WIDTH-1:0] pick_idx_s;
  logic [NUM_RESIZE-1:0]  pick_onehot_s;
  logic                   any_req_s;
  logic                   all_pix_s;

  // Scanning offsets from farthest to nearest leaves the nearest requester after ptr selected.
  function automatic logic [INDEX_WIDTH-1:0] rr_pick(input logic [NUM_RESIZE-1:0] req,
                                                     input logic [INDEX_WIDTH-1:0] ptr);
    logic [INDEX_WIDTH-1:0] sel;
    logic [INDEX_WIDTH-1:0] k;
    sel = ptr;
    for (int i = NUM_RESIZE; i >= 1; i--) begin
      k = INDEX_WIDTH'((int'(ptr) + i) % NUM_RESIZE);
      if (req[k]) begin
        sel = k;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Arbitration decode for the next grant.
  always_comb begin
    any_req_s     = |database_request;
    all_pix_s     = &pixel_request;
    pick_idx_s    = rr_pick(database_request, ptr_r);
    pick_onehot_s = {{(NUM_RESIZE-1){1'b0}}, 1'b1} << pick_idx_s;
  end

  assign o_candidate = cand_r;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r               <= IDLE;
      ptr_r                 <= PTR_RESET;
      sweep_cnt_r           <= 16'd0;
      cand_r                <= '0;
      o_grant               <= '0;
      o_grant_index         <= '0;
      o_database_reset      <= 1'b0;
      o_database_enable     <= 1'b0;
      o_write_result        <= 1'b0;
      o_ready_recieve_pixel <= 1'b0;
      o_busy                <= 1'b0;
      o_timeout             <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            o_grant          <= pick_onehot_s;
            o_grant_index    <= pick_idx_s;
            o_database_reset <= 1'b1;
            o_busy           <= 1'b1;
            state_r          <= LOAD;
          end else if (all_pix_s) begin
            o_busy  <= 1'b1;
            state_r <= COLLECT;
          end else begin
            o_busy  <= 1'b0;
          end
        end
        LOAD: begin
          o_database_reset  <= 1'b0;
          o_database_enable <= 1'b1;
          sweep_cnt_r       <= 16'd0;
          state_r           <= SWEEP;
        end
        SWEEP: begin
          // A sweep end on the timeout cycle still counts as a clean finish.
          if (database_end) begin
            cand_r            <= cand_r | (candidate & o_grant);
            ptr_r             <= o_grant_index;
            o_grant           <= '0;
            o_database_enable <= 1'b0;
            o_busy            <= 1'b0;
            state_r           <= IDLE;
          end else if (sweep_cnt_r == SWEEP_LAST) begin
            ptr_r             <= o_grant_index;
            o_grant           <= '0;
            o_database_enable <= 1'b0;
            o_busy            <= 1'b0;
            o_timeout         <= 1'b1;
            state_r           <= IDLE;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + 16'd1;
          end
        end
        COLLECT: begin
          if (|cand_r) begin
            o_write_result <= 1'b1;
            state_r        <= WRITE;
          end else begin
            o_ready_recieve_pixel <= 1'b1;
            state_r               <= READY;
          end
        end
        WRITE: begin
          if (result_write_end) begin
            o_write_result        <= 1'b0;
            o_ready_recieve_pixel <= 1'b1;
            state_r               <= READY;
          end else begin
            o_write_result <= 1'b1;
          end
        end
        READY: begin
          o_ready_recieve_pixel <= 1'b0;
          cand_r                <= '0;
          state_r               <= WAIT_PIXEL;
        end
        WAIT_PIXEL: begin
          if (pixel_recieve) begin
            o_busy  <= 1'b0;
            state_r <= IDLE;
          end else begin
            o_busy  <= 1'b1;
          end
        end
        default: begin
          o_grant               <= '0;
          o_database_reset      <= 1'b0;
          o_database_enable     <= 1'b0;
          o_write_result        <= 1'b0;
          o_ready_recieve_pixel <= 1'b0;
          o_busy                <= 1'b0;
          state_r               <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_database_scheduler.sv
// Randomized self-checking bench for database_scheduler against a transaction-level model
// (round-robin owner, candidate OR-latch, sticky timeout).
module tb_database_scheduler;

  localparam int NR  = 5;
  localparam int IW  = 3;
  localparam int TMO = 16;

  logic          clk;
  logic          reset;
  logic [NR-1:0] database_request;
  logic [NR-1:0] pixel_request;
  logic [NR-1:0] candidate;
  logic          database_end;
  logic          result_write_end;
  logic          pixel_recieve;
  logic [NR-1:0] o_grant;
  logic [IW-1:0] o_grant_index;
  logic          o_database_reset;
  logic          o_database_enable;
  logic [NR-1:0] o_candidate;
  logic          o_write_result;
  logic          o_ready_recieve_pixel;
  logic          o_busy;
  logic          o_timeout;

  int n_checks;
  int n_fail;

  int            m_ptr;
  logic [NR-1:0] m_latch;
  logic          m_timeout;

  database_scheduler #(
    .NUM_RESIZE(NR),
    .INDEX_WIDTH(IW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .database_request(database_request),
    .pixel_request(pixel_request),
    .candidate(candidate),
    .database_end(database_end),
    .result_write_end(result_write_end),
    .pixel_recieve(pixel_recieve),
    .o_grant(o_grant),
    .o_grant_index(o_grant_index),
    .o_database_reset(o_database_reset),
    .o_database_enable(o_database_enable),
    .o_candidate(o_candidate),
    .o_write_result(o_write_result),
    .o_ready_recieve_pixel(o_ready_recieve_pixel),
    .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_next(input logic [NR-1:0] req, input int ptr);
    int s;
    for (int off = 1; off <= NR; off++) begin
      s = (ptr + off) % NR;
      if (req[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr     = NR - 1;
    m_latch   = '0;
    m_timeout = 1'b0;
  endtask

  task automatic check_all_zero(input string where);
    chk_eq({where, "_grant"},  o_grant, 0);
    chk_eq({where, "_index"},  o_grant_index, 0);
    chk_eq({where, "_dbrst"},  o_database_reset, 0);
    chk_eq({where, "_enable"}, o_database_enable, 0);
    chk_eq({where, "_cand"},   o_candidate, 0);
    chk_eq({where, "_write"},  o_write_result, 0);
    chk_eq({where, "_ready"},  o_ready_recieve_pixel, 0);
    chk_eq({where, "_busy"},   o_busy, 0);
    chk_eq({where, "_tmo"},    o_timeout, 0);
  endtask

  // One sweep: database_end is raised after d quiet sweep cycles (d >= TMO means never).
  task automatic run_sweep(input logic [NR-1:0] req, input int d, input logic [NR-1:0] cand,
                           input bit keep);
    int idx, exp_len, ena_cnt, rst_cnt;
    bit timed;
    logic [NR-1:0] oh;
    idx = rr_next(req, m_ptr);
    oh  = 5'b00001 << idx;
    database_request = req;
    tick();
    chk_eq("grant", o_grant, oh);
    chk_eq("grant_index", o_grant_index, idx);
    chk_eq("db_reset_pulse", o_database_reset, 1);
    chk_eq("enable_at_load", o_database_enable, 0);
    chk_eq("busy_at_load", o_busy, 1);
    if (!keep) database_request = '0;
    timed   = (d > TMO - 1);
    exp_len = timed ? TMO : d + 1;
    ena_cnt = 0;
    rst_cnt = 0;
    for (int j = 0; j <= exp_len; j++) begin
      if (j == d + 1) begin
        database_end = 1'b1;
        candidate    = cand;
      end else begin
        database_end = 1'b0;
        candidate    = NR'($urandom);
      end
      tick();
      if (o_database_enable) ena_cnt++;
      if (o_database_reset) rst_cnt++;
    end
    database_end = 1'b0;
    candidate    = '0;
    if (timed) m_timeout = 1'b1;
    else       m_latch   = m_latch | (cand & oh);
    m_ptr = idx;
    chk_eq("enable_cycles", ena_cnt, exp_len);
    chk_eq("db_reset_extra", rst_cnt, 0);
    chk_eq("enable_after", o_database_enable, 0);
    chk_eq("grant_after", o_grant, 0);
    chk_eq("index_hold", o_grant_index, idx);
    chk_eq("busy_after", o_busy, 0);
    chk_eq("timeout_flag", o_timeout, m_timeout);
    chk_eq("cand_latch", o_candidate, m_latch);
  endtask

  // One pixel round: collect, optional write, ready pulse, wait for the pixel.
  task automatic run_pixel(input int wdelay, input int wait_cycles);
    int wr_cnt, bad;
    pixel_request = 5'b11111;
    tick();
    chk_eq("collect_busy", o_busy, 1);
    chk_eq("collect_ready", o_ready_recieve_pixel, 0);
    tick();
    if (m_latch != '0) begin
      chk_eq("write_req", o_write_result, 1);
      chk_eq("ready_early", o_ready_recieve_pixel, 0);
      wr_cnt = 0;
      for (int j = 0; j < wdelay; j++) begin
        tick();
        if (o_write_result) wr_cnt++;
      end
      chk_eq("write_hold", wr_cnt, wdelay);
      result_write_end = 1'b1;
      tick();
      result_write_end = 1'b0;
    end
    chk_eq("write_done", o_write_result, 0);
    chk_eq("ready_pulse", o_ready_recieve_pixel, 1);
    chk_eq("cand_at_ready", o_candidate, m_latch);
    tick();
    m_latch = '0;
    chk_eq("ready_one_cycle", o_ready_recieve_pixel, 0);
    chk_eq("cand_cleared", o_candidate, 0);
    chk_eq("wait_busy", o_busy, 1);
    bad = 0;
    for (int j = 0; j < wait_cycles; j++) begin
      database_request = NR'($urandom);
      database_end     = 1'($urandom);
      candidate        = NR'($urandom);
      tick();
      if (o_ready_recieve_pixel || o_grant != '0 || o_database_reset || o_write_result ||
          o_candidate != '0 || !o_busy) bad++;
    end
    chk_eq("wait_ignores", bad, 0);
    database_request = '0;
    database_end     = 1'b0;
    candidate        = '0;
    pixel_recieve    = 1'b1;
    tick();
    pixel_recieve = 1'b0;
    pixel_request = '0;
    chk_eq("pixel_to_idle", o_busy, 0);
    tick();
    chk_eq("idle_stays", o_busy, 0);
  endtask

  initial begin
    logic [NR-1:0] req;
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    reset            = 1'b0;
    database_request = '0;
    pixel_request    = '0;
    candidate        = '0;
    database_end     = 1'b0;
    result_write_end = 1'b0;
    pixel_recieve    = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // single sweep of scale 2, end 10 cycles after enable
    run_sweep(5'b00100, 10, 5'b00000, 1'b0);

    // round robin with every scale requesting continuously
    model_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) run_sweep(5'b11111, 4, 5'b00000, 1'b1);
    database_request = '0;
    tick();

    // stray end/write pulses while idle are ignored
    database_end     = 1'b1;
    candidate        = 5'b11111;
    result_write_end = 1'b1;
    tick();
    database_end     = 1'b0;
    candidate        = '0;
    result_write_end = 1'b0;
    tick();
    chk_eq("idle_end_ignored", o_candidate, m_latch);
    chk_eq("idle_not_busy", o_busy, 0);

    // candidate path: scales 1 and 3 flag a face
    run_sweep(5'b00010, 3, 5'b11111, 1'b0);
    run_sweep(5'b01000, 2, 5'b11111, 1'b0);
    chk_eq("cand_01010", o_candidate, 5'b01010);
    run_pixel(3, 2);

    // no-candidate path
    run_pixel(0, 4);

    // end coincides with the last legal cycle: end wins
    run_sweep(5'b00001, TMO - 1, 5'b00001, 1'b0);
    // timeout: candidate must not be latched, flag sticks
    run_sweep(5'b10000, TMO + 3, 5'b11111, 1'b0);
    run_sweep(5'b00100, 1, 5'b00000, 1'b0);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_pixel($urandom_range(0, 4), $urandom_range(0, 4));
      end else begin
        req = NR'($urandom);
        if (req == '0) req = 5'b00001;
        run_sweep(req, $urandom_range(0, TMO + 2), NR'($urandom), 1'b0);
      end
    end

    // asynchronous reset in the middle of a sweep
    database_request = 5'b01000;
    tick();
    database_request = '0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_sweep");
    model_reset();
    tick();
    #3 reset = 1'b1;
    tick();
    run_sweep(5'b11111, 3, 5'b00000, 1'b0);

    // asynchronous reset in the middle of a write
    run_sweep(5'b00010, 2, 5'b11111, 1'b0);
    pixel_request = 5'b11111;
    tick();
    tick();
    tick();
    chk_eq("pre_reset_write", o_write_result, 1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_write");
    model_reset();
    pixel_request = '0;
    tick();
    #3 reset = 1'b1;
    tick();
    run_sweep(5'b10001, 1, 5'b00000, 1'b0);
    run_pixel(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/database_scheduler.md
# database_scheduler

Time-multiplexes the single shared Haar classifier database between the NUM_RESIZE per-scale I2LBS inspectors. It grants database sweeps one scale at a time in round-robin order and restarts the database before each sweep. Once every scale is waiting for a pixel, it accumulates the per-scale candidate flags, drives the result write handshake, and releases the next camera pixel. It sits between the I2LBS instances, haar_database and result inside face_detection.

## Interface
- NUM_RESIZE, 5, number of scale requesters.
- INDEX_WIDTH, 3, width of the grant index; must be at least clog2(NUM_RESIZE).
- TIMEOUT_CYCLES, 50000, maximum SWEEP length in cycles; legal range 2 to 65535.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- database_request  in  NUM_RESIZE  level request per scale for a database sweep.
- pixel_request  in  NUM_RESIZE  level, per scale "waiting for next pixel".
- candidate  in  NUM_RESIZE  per-scale face-candidate flag; valid while database_end is high.
- database_end  in  1  one-cycle pulse from haar_database at the end of a full sweep.
- result_write_end  in  1  one-cycle pulse from result when the write has completed.
- pixel_recieve  in  1  one-cycle pulse when the pixel source delivers a pixel.
- o_grant  out  NUM_RESIZE  one-hot grant; all zero when no sweep is owned.
- o_grant_index  out  INDEX_WIDTH  binary index of the granted scale; holds its last value when idle.
- o_database_reset  out  1  one-cycle restart pulse to haar_database.
- o_database_enable  out  1  database advance enable.
- o_candidate  out  NUM_RESIZE  accumulated candidates for the current pixel, for result.
- o_write_result  out  1  result write request; held high until result_write_end.
- o_ready_recieve_pixel  out  1  one-cycle pulse requesting the next pixel.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  sticky flag; set on a sweep timeout, cleared only by reset.

## Operation
States: IDLE, LOAD, SWEEP, COLLECT, WRITE, READY, WAIT_PIXEL. All outputs are registered.

Reset:
- All outputs are 0; state is IDLE.
- The round-robin pointer is NUM_RESIZE-1, so the first grant goes to scale 0.
- The sweep counter and the candidate latch are 0.

IDLE:
- If any database_request bit is set, go to LOAD. Database requests take priority over pixel collection.
- The grant goes to the first requesting bit, searching cyclically from pointer+1.
- Register o_grant and o_grant_index, and set o_database_reset=1.
- Otherwise, if pixel_request is all ones, go to COLLECT.

LOAD (exactly 1 cycle):
- o_database_reset returns to 0; o_database_enable=1.
- Clear the sweep counter; go to SWEEP.

SWEEP:
- Hold o_database_enable=1; the counter increments every cycle.
- On database_end: OR candidate[grant index] into the candidate latch, set pointer = grant index, and go to IDLE.
- Also on database_end: o_grant=0 and o_database_enable=0, effective on that same edge.
- On timeout (counter == TIMEOUT_CYCLES-1 with no database_end): same exit, but the candidate is not latched and o_timeout is set.
- If database_end and timeout occur in the same cycle, database_end wins and o_timeout is not set.
- A requester dropping database_request mid-sweep does not abort the sweep.

COLLECT (1 cycle):
- If the candidate latch is non-zero, go to WRITE with o_write_result=1; otherwise go to READY.

WRITE:
- Hold o_write_result=1.
- On result_write_end: o_write_result=0, go to READY.

READY (1 cycle):
- o_ready_recieve_pixel=1 for this cycle only.
- Clear the candidate latch; go to WAIT_PIXEL.

WAIT_PIXEL:
- Ignore pixel_request and database_request.
- On pixel_recieve, go to IDLE.

Other rules:
- database_end outside SWEEP and result_write_end outside WRITE are ignored.
- o_candidate always equals the candidate latch.
- Reset asserted in any state returns everything to reset values asynchronously. No restart pulse is issued until a new grant.

## Timing
- Request to database: database_request seen at edge N gives o_database_reset=1 in cycle N+1 and o_database_enable=1 from N+2.
- Sweep end: database_end at edge M drops enable and grant after edge M. The earliest next o_database_reset is at edge M+1.
- Fairness: back-to-back requests from all scales are served 0,1,2,3,4,0,… with 2 cycles of overhead per sweep.
- Pixel release without candidates: all-ones pixel_request at edge N in IDLE gives COLLECT at N+1 and the o_ready_recieve_pixel pulse at N+2.
- Pixel release with candidates: the pulse comes 1 cycle after the result_write_end edge.
- Sweep counter: 16 bits, saturating at TIMEOUT_CYCLES-1.

## Test plan
- Reset and single sweep: release reset, raise database_request=5'b00100, pulse database_end 10 cycles after enable -> o_database_reset pulses once, o_grant=5'b00100, o_grant_index=2, enable high for exactly 11 cycles, then IDLE with o_busy=0.
- Round-robin: hold database_request=5'b11111 with database_end pulsed 5 cycles into each sweep -> grant order 0,1,2,3,4,0; no two sweeps overlap.
- Candidate path: sweeps for scales 1 and 3 with candidate high at database_end, then pixel_request=5'b11111 -> o_candidate=5'b01010, o_write_result held until result_write_end, o_ready_recieve_pixel one cycle later, o_candidate returns to 0.
- No-candidate path: pixel_request=5'b11111 with the latch empty -> no o_write_result, ready pulse 2 cycles after the request, no new COLLECT before a pixel_recieve pulse.
- Timeout: TIMEOUT_CYCLES=8, grant scale 0, never pulse database_end -> enable drops after 8 SWEEP cycles, o_timeout=1 and remains 1, candidate not latched.
- Asynchronous reset mid-SWEEP and mid-WRITE: drive reset low between clock edges -> all outputs 0 immediately; after release, the next grant goes to scale 0.
